// File: rtl/core101_mem_master_if.sv
// Core101 memory master bus bundle.
// Groups the core-side request/response handshake and the external memory
// bus into one interface.
//   master : view of core101_mem_master (drives ready/resp/mem strobes)
//   slave  : view of the surroundings (core plus external memory)
interface core101_mem_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid_in;
  logic                    req_ready_out;
  logic                    req_write_in;
  logic [ADDR_WIDTH-1:0]   req_addr_in;
  logic [DATA_WIDTH-1:0]   req_wdata_in;
  logic [DATA_WIDTH/8-1:0] req_wstrb_in;
  logic                    resp_valid_out;
  logic                    resp_ready_in;
  logic [DATA_WIDTH-1:0]   resp_rdata_out;
  logic                    resp_error_out;
  logic [ADDR_WIDTH-1:0]   mem_addr_out;
  logic [DATA_WIDTH-1:0]   mem_wdata_out;
  logic [DATA_WIDTH/8-1:0] mem_wstrb_out;
  logic [DATA_WIDTH-1:0]   mem_rdata_in;
  logic                    mem_read_out;
  logic                    mem_write_out;
  logic                    mem_valid_in;

  modport master (
    input  req_valid_in, req_write_in, req_addr_in, req_wdata_in, req_wstrb_in,
    input  resp_ready_in, mem_rdata_in, mem_valid_in,
    output req_ready_out, resp_valid_out, resp_rdata_out, resp_error_out,
    output mem_addr_out, mem_wdata_out, mem_wstrb_out, mem_read_out, mem_write_out
  );

  modport slave (
    output req_valid_in, req_write_in, req_addr_in, req_wdata_in, req_wstrb_in,
    output resp_ready_in, mem_rdata_in, mem_valid_in,
    input  req_ready_out, resp_valid_out, resp_rdata_out, resp_error_out,
    input  mem_addr_out, mem_wdata_out, mem_wstrb_out, mem_read_out, mem_write_out
  );
endinterface

// File: rtl/core101_mem_master.sv
// Core101 memory master.
// Takes single read/write requests from the core, runs one access on the
// external memory bus, waits for mem_valid_in (with optional timeout) and
// returns data plus an error flag. Misaligned requests are answered with an
// error without touching memory.
// Ports:
//   clock_in      : system clock, rising edge
//   reset_in      : asynchronous active-low reset
//   bus           : request/response handshake and memory bus (master view)
//   err_count_out : saturating count of error responses
//
// state  | meaning
// IDLE   | ready for a request, no strobe
// ACCESS | strobe asserted, waiting for mem_valid_in or timeout
// RESP   | response presented until resp_ready_in
module core101_mem_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  core101_mem_master_if.master     bus,
  output logic [ERR_CNT_WIDTH-1:0] err_count_out
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TO_LAST);

  // Low address bits that must be zero for a naturally aligned access;
  // all-zero for an 8-bit bus, so nothing is ever misaligned there.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

  logic [1:0]              state;
  logic                    req_ready_q;
  logic                    resp_valid_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q;
  logic                    resp_error_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [DATA_WIDTH/8-1:0] mem_wstrb_q;
  logic                    mem_read_q;
  logic                    mem_write_q;
  logic                    is_write_q;
  logic [TO_W-1:0]         to_cnt;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  logic misaligned;
  logic timed_out;

  assign misaligned = (bus.req_addr_in & ALIGN_MASK) != '0;
  // Down-counter loaded with TIMEOUT_CYCLES-1 on entry; terminal count
  // at zero matches an up-count from 0 reaching TIMEOUT_CYCLES-1.
  assign timed_out  = (TIMEOUT_CYCLES != 0) && (to_cnt == '0);

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state        <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      is_write_q   <= 1'b0;
      to_cnt       <= '0;
      err_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid_in && req_ready_q) begin
            req_ready_q <= 1'b0;
            mem_addr_q  <= bus.req_addr_in;
            mem_wdata_q <= bus.req_wdata_in;
            mem_wstrb_q <= bus.req_wstrb_in;
            is_write_q  <= bus.req_write_in;
            to_cnt      <= TO_LOAD;
            if (misaligned) begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
              resp_error_q <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
              state <= ST_RESP;
            end else begin
              mem_read_q  <= ~bus.req_write_in;
              mem_write_q <= bus.req_write_in;
              state       <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // valid has priority over a timeout in the same cycle
          if (bus.mem_valid_in) begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= is_write_q ? '0 : bus.mem_rdata_in;
            resp_error_q <= 1'b0;
            state        <= ST_RESP;
          end else if (timed_out) begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            state        <= ST_RESP;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready_in) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: begin
          state        <= ST_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_out  = req_ready_q;
  assign bus.resp_valid_out = resp_valid_q;
  assign bus.resp_rdata_out = resp_rdata_q;
  assign bus.resp_error_out = resp_error_q;
  assign bus.mem_addr_out   = mem_addr_q;
  assign bus.mem_wdata_out  = mem_wdata_q;
  assign bus.mem_wstrb_out  = mem_wstrb_q;
  assign bus.mem_read_out   = mem_read_q;
  assign bus.mem_write_out  = mem_write_q;
  assign err_count_out      = err_cnt;

endmodule

// File: tb/tb_core101_mem_master.sv
module tb_core101_mem_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int EW = 8;

  logic clock_in;
  logic reset_in;
  logic [EW-1:0] err_count_out;

  int checks   = 0;
  int failures = 0;

  core101_mem_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  core101_mem_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .ERR_CNT_WIDTH(EW)
  ) dut (
    .clock_in      (clock_in),
    .reset_in      (reset_in),
    .bus           (bus.master),
    .err_count_out (err_count_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    bus.req_valid_in = 1'b1;
    bus.req_write_in = w;
    bus.req_addr_in  = a;
    bus.req_wdata_in = d;
    bus.req_wstrb_in = s;
    tick();
    bus.req_valid_in = 1'b0;
  endtask

  // Counts strobe-high cycles; optionally answers on the (wait_cyc+1)th one.
  task automatic run_mem(input int wait_cyc, input bit give_valid,
                         input logic [DW-1:0] rd, output int hi);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (!(bus.mem_read_out || bus.mem_write_out)) break;
      hi++;
      if (give_valid && hi == wait_cyc + 1) begin
        bus.mem_valid_in = 1'b1;
        bus.mem_rdata_in = rd;
      end
      tick();
      bus.mem_valid_in = 1'b0;
    end
  endtask

  task automatic finish_resp(input string tag, input logic [DW-1:0] exp_rd,
                             input logic exp_err);
    int n = 0;
    while (!bus.resp_valid_out && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_resp_valid"}, bus.resp_valid_out, 1'b1);
    chk({tag, "_rdata"}, bus.resp_rdata_out, exp_rd);
    chk({tag, "_error"}, bus.resp_error_out, exp_err);
    chk({tag, "_ready_in_resp"}, bus.req_ready_out, 1'b0);
    bus.resp_ready_in = 1'b1;
    tick();
    bus.resp_ready_in = 1'b0;
    chk({tag, "_resp_done"}, bus.resp_valid_out, 1'b0);
    chk({tag, "_ready_back"}, bus.req_ready_out, 1'b1);
  endtask

  int hi;

  initial begin
    reset_in          = 1'b0;
    bus.req_valid_in  = 1'b0;
    bus.req_write_in  = 1'b0;
    bus.req_addr_in   = '0;
    bus.req_wdata_in  = '0;
    bus.req_wstrb_in  = '0;
    bus.resp_ready_in = 1'b0;
    bus.mem_rdata_in  = '0;
    bus.mem_valid_in  = 1'b0;
    tick();
    tick();
    chk("rst_ready", bus.req_ready_out, 1'b1);
    chk("rst_resp_valid", bus.resp_valid_out, 1'b0);
    chk("rst_read", bus.mem_read_out, 1'b0);
    chk("rst_write", bus.mem_write_out, 1'b0);
    chk("rst_errcnt", err_count_out, 8'd0);
    reset_in = 1'b1;
    tick();

    // 1: read with 2 wait cycles
    send_req(1'b0, 32'h100, 32'h0, 4'hF);
    chk("t1_read_hi", bus.mem_read_out, 1'b1);
    chk("t1_addr", bus.mem_addr_out, 32'h100);
    chk("t1_ready_low", bus.req_ready_out, 1'b0);
    run_mem(2, 1'b1, 32'hDEADBEEF, hi);
    chk("t1_strobe_cycles", hi, 3);
    finish_resp("t1", 32'hDEADBEEF, 1'b0);
    chk("t1_errcnt", err_count_out, 8'd0);

    // 2: write zero-wait
    send_req(1'b1, 32'h204, 32'h12345678, 4'b0011);
    chk("t2_write_hi", bus.mem_write_out, 1'b1);
    chk("t2_read_lo", bus.mem_read_out, 1'b0);
    chk("t2_addr", bus.mem_addr_out, 32'h204);
    chk("t2_wdata", bus.mem_wdata_out, 32'h12345678);
    chk("t2_wstrb", bus.mem_wstrb_out, 4'b0011);
    run_mem(0, 1'b1, 32'hFFFF0000, hi);
    chk("t2_strobe_cycles", hi, 1);
    finish_resp("t2", 32'h0, 1'b0);

    // 3: misaligned read
    send_req(1'b0, 32'h102, 32'h0, 4'hF);
    chk("t3_no_read", bus.mem_read_out, 1'b0);
    chk("t3_no_write", bus.mem_write_out, 1'b0);
    finish_resp("t3", 32'h0, 1'b1);
    chk("t3_errcnt", err_count_out, 8'd1);

    // 4a: timeout
    send_req(1'b0, 32'h180, 32'h0, 4'hF);
    run_mem(0, 1'b0, 32'h0, hi);
    chk("t4a_strobe_cycles", hi, 16);
    finish_resp("t4a", 32'h0, 1'b1);
    chk("t4a_errcnt", err_count_out, 8'd2);

    // 4b: valid in the final cycle wins over the timeout
    send_req(1'b0, 32'h184, 32'h0, 4'hF);
    run_mem(15, 1'b1, 32'hCAFEF00D, hi);
    chk("t4b_strobe_cycles", hi, 16);
    finish_resp("t4b", 32'hCAFEF00D, 1'b0);
    chk("t4b_errcnt", err_count_out, 8'd2);

    // 5: stalled response with new request and spurious mem_valid
    send_req(1'b0, 32'h300, 32'h0, 4'hF);
    run_mem(0, 1'b1, 32'hA5A5_5A5A, hi);
    bus.req_valid_in = 1'b1;
    bus.req_write_in = 1'b0;
    bus.req_addr_in  = 32'h400;
    bus.mem_valid_in = 1'b1;
    bus.mem_rdata_in = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", bus.resp_valid_out, 1'b1);
      chk("t5_hold_rdata", bus.resp_rdata_out, 32'hA5A5_5A5A);
      chk("t5_hold_ready", bus.req_ready_out, 1'b0);
      chk("t5_no_strobe", bus.mem_read_out, 1'b0);
      tick();
    end
    bus.resp_ready_in = 1'b1;
    tick();
    bus.resp_ready_in = 1'b0;
    bus.req_valid_in  = 1'b0;
    bus.mem_valid_in  = 1'b0;
    chk("t5_resp_done", bus.resp_valid_out, 1'b0);
    chk("t5_ready_back", bus.req_ready_out, 1'b1);
    tick();
    chk("t5_not_accepted", bus.mem_read_out, 1'b0);
    chk("t5_still_ready", bus.req_ready_out, 1'b1);

    // 6: reset during ACCESS
    send_req(1'b0, 32'h500, 32'h0, 4'hF);
    tick();
    chk("t6_read_before", bus.mem_read_out, 1'b1);
    reset_in = 1'b0;
    #1;
    chk("t6_read_dropped", bus.mem_read_out, 1'b0);
    chk("t6_ready_high", bus.req_ready_out, 1'b1);
    chk("t6_errcnt", err_count_out, 8'd0);
    tick();
    reset_in = 1'b1;
    bus.mem_valid_in = 1'b1;
    tick();
    bus.mem_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_resp", bus.resp_valid_out, 1'b0);
      chk("t6_no_strobe", bus.mem_read_out, 1'b0);
      tick();
    end
    chk("t6_errcnt_end", err_count_out, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
